// File: rtl/aes128_key_schedule.sv
// AES-128 key expansion engine: streams round keys 0..10 through a start/valid/done handshake.
// Optional round-key register file with registered read port when KEY_SCHED_RK_STORE_EN is defined.

module sub_bytes (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; zero maps to zero for free.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv   = ginv(in_i);
        out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes128_key_schedule #(
    parameter int SBOX_LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_index,
    output logic [127:0] round_key,
    output logic         done
`ifdef KEY_SCHED_RK_STORE_EN
    ,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
`endif
);
    localparam bit SERIAL = (SBOX_LANES == 1);

    typedef enum logic [1:0] {IDLE, SUB, MIX} state_t;

    state_t       state_q;
    logic         busy_q, rk_valid_q, done_q;
    logic [3:0]   rk_index_q;
    logic [127:0] round_key_q;
    logic [31:0]  w_q [4];
    logic [31:0]  w_d [4];
    logic [31:0]  temp_q, temp_d;
    logic [1:0]   cnt_q;
    logic [7:0]   rcon_q, rcon_d;
    logic [31:0]  rot_w;

    assign rot_w = {w_q[3][23:0], w_q[3][31:24]};

    if (SBOX_LANES == 4) begin : g_par
        logic [31:0] sub_w;
        for (genvar i = 0; i < 4; i++) begin : g_lane
            sub_bytes u_sbox (.in_i(rot_w[31-8*i -: 8]), .out_o(sub_w[31-8*i -: 8]));
        end
        assign temp_d = sub_w;
    end else if (SBOX_LANES == 1) begin : g_ser
        logic [7:0] sb_in, sb_out;
        sub_bytes u_sbox (.in_i(sb_in), .out_o(sb_out));
        always_comb begin
            case (cnt_q)
                2'd0:    sb_in = rot_w[31:24];
                2'd1:    sb_in = rot_w[23:16];
                2'd2:    sb_in = rot_w[15:8];
                default: sb_in = rot_w[7:0];
            endcase
        end
        // Counter k lands its substituted byte at temp[31-8k -: 8].
        always_comb begin
            temp_d = temp_q;
            case (cnt_q)
                2'd0:    temp_d[31:24] = sb_out;
                2'd1:    temp_d[23:16] = sb_out;
                2'd2:    temp_d[15:8]  = sb_out;
                default: temp_d[7:0]   = sb_out;
            endcase
        end
    end else begin : g_bad
        $error("aes128_key_schedule: SBOX_LANES must be 4 or 1");
    end

    always_comb begin
        w_d[0] = w_q[0] ^ temp_q ^ {rcon_q, 24'h0};
        w_d[1] = w_q[1] ^ w_d[0];
        w_d[2] = w_q[2] ^ w_d[1];
        w_d[3] = w_q[3] ^ w_d[2];
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            rk_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            rk_index_q  <= 4'd0;
            round_key_q <= 128'h0;
            for (int i = 0; i < 4; i++) w_q[i] <= 32'h0;
            temp_q      <= 32'h0;
            cnt_q       <= 2'd0;
            rcon_q      <= 8'h01;
        end else begin
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A start landing on the done cycle is dropped, not deferred.
                    if (start && !done_q) begin
                        w_q[0]      <= key_in[127:96];
                        w_q[1]      <= key_in[95:64];
                        w_q[2]      <= key_in[63:32];
                        w_q[3]      <= key_in[31:0];
                        round_key_q <= key_in;
                        rk_index_q  <= 4'd0;
                        rk_valid_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        rcon_q      <= 8'h01;
                        cnt_q       <= 2'd0;
                        state_q     <= SUB;
                    end
                end
                SUB: begin
                    temp_q <= temp_d;
                    cnt_q  <= SERIAL ? cnt_q + 2'd1 : 2'd0;
                    if (!SERIAL || cnt_q == 2'd3) state_q <= MIX;
                end
                MIX: begin
                    for (int i = 0; i < 4; i++) w_q[i] <= w_d[i];
                    round_key_q <= {w_d[0], w_d[1], w_d[2], w_d[3]};
                    rk_index_q  <= rk_index_q + 4'd1;
                    rk_valid_q  <= 1'b1;
                    rcon_q      <= rcon_d;
                    if (rk_index_q == 4'd9) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= SUB;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign rk_valid  = rk_valid_q;
    assign rk_index  = rk_index_q;
    assign round_key = round_key_q;
    assign done      = done_q;

`ifdef KEY_SCHED_RK_STORE_EN
    logic [127:0] rf_q [11];
    logic [127:0] rd_key_q;

    // Write trails presentation by the register stage, so a same-index read sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) rf_q[i] <= 128'h0;
            rd_key_q <= 128'h0;
        end else begin
            if (rk_valid_q) rf_q[rk_index_q] <= round_key_q;
            rd_key_q <= (rd_idx <= 4'd10) ? rf_q[rd_idx] : 128'h0;
        end
    end

    assign rd_key = rd_key_q;
`endif
endmodule

// File: tb/tb_aes128_key_schedule.sv
// Scoreboard bench for aes128_key_schedule: a 4-lane and a 1-lane instance driven with FIPS-197 and all-zero keys.
module tb_aes128_key_schedule;
    localparam logic [127:0] FIPS_RK [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    localparam logic [127:0] ZERO_RK [11] = '{
        128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b, 128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7, 128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f, 128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
        logic         done;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, s4, s1;
    logic [127:0] k4, k1;
    logic         busy4, rkv4, done4, busy1, rkv1, done1;
    logic [3:0]   rki4, rki1;
    logic [127:0] rk4, rk1;
`ifdef KEY_SCHED_RK_STORE_EN
    logic [3:0]   rdi4, rdi1;
    logic [127:0] rdk4, rdk1;
`endif

    aes128_key_schedule #(.SBOX_LANES(4)) u4 (
        .clk(clk), .rst(rst), .start(s4), .key_in(k4), .busy(busy4), .rk_valid(rkv4),
        .rk_index(rki4), .round_key(rk4), .done(done4)
`ifdef KEY_SCHED_RK_STORE_EN
        , .rd_idx(rdi4), .rd_key(rdk4)
`endif
    );

    aes128_key_schedule #(.SBOX_LANES(1)) u1 (
        .clk(clk), .rst(rst), .start(s1), .key_in(k1), .busy(busy1), .rk_valid(rkv1),
        .rk_index(rki1), .round_key(rk1), .done(done1)
`ifdef KEY_SCHED_RK_STORE_EN
        , .rd_idx(rdi1), .rd_key(rdk1)
`endif
    );

    int   checks = 0, errors = 0, cyc = 0;
    int   last4 = 0, last1 = 0, pulses4 = 0;
    exp_t q4[$], q1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input bit lane1, input bit zero, input int last);
        for (int i = 0; i <= last; i++) begin
            exp_t e;
            e.idx  = i[3:0];
            e.key  = zero ? ZERO_RK[i] : FIPS_RK[i];
            e.done = (i == 10);
            if (lane1) q1.push_back(e);
            else       q4.push_back(e);
        end
    endtask

    task automatic wait_done(input bit lane1, input int c0, input int lat, input string name);
        int n;
        n = 0;
        while (!(lane1 ? done1 : done4) && n < 300) begin
            tick();
            n++;
        end
        check(name, cyc - c0, lat);
    endtask

    task automatic wait_idx4(input logic [3:0] idx);
        int n;
        n = 0;
        while (!(rkv4 && rki4 == idx) && n < 100) begin
            tick();
            n++;
        end
        check("wait_rk_index", (n < 100), 1);
    endtask

    always @(negedge clk) begin : mon4
        exp_t e;
        if (rkv4) begin
            pulses4++;
            if (q4.size() == 0) begin
                check("mon4_unexpected_rk", {rki4, rk4[123:0]}, 128'h0);
            end else begin
                e = q4.pop_front();
                check("mon4_index", rki4, e.idx);
                check("mon4_key", rk4, e.key);
                check("mon4_done", done4, e.done);
                check("mon4_busy", busy4, (e.idx != 4'd10));
                if (e.idx != 4'd0) check("mon4_spacing", cyc - last4, 2);
            end
            last4 = cyc;
        end else if (done4) begin
            check("mon4_done_without_valid", done4, 0);
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rkv1) begin
            if (q1.size() == 0) begin
                check("mon1_unexpected_rk", {rki1, rk1[123:0]}, 128'h0);
            end else begin
                e = q1.pop_front();
                check("mon1_index", rki1, e.idx);
                check("mon1_key", rk1, e.key);
                check("mon1_done", done1, e.done);
                if (e.idx != 4'd0) check("mon1_spacing", cyc - last1, 5);
            end
            last1 = cyc;
        end else if (done1) begin
            check("mon1_done_without_valid", done1, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, p0;
        rst = 1'b1; s4 = 1'b0; s1 = 1'b0; k4 = '0; k1 = '0;
`ifdef KEY_SCHED_RK_STORE_EN
        rdi4 = 4'd0; rdi1 = 4'd0;
`endif
        repeat (3) tick();
        check("rst_busy", busy4, 0);
        check("rst_rk_valid", rkv4, 0);
        check("rst_done", done4, 0);
        check("rst_rk_index", rki4, 0);
        check("rst_round_key", rk4, 0);
        check("rst_round_key_1lane", rk1, 0);
        rst = 1'b0;
        tick();

        // FIPS-197 key, 4 lanes; key_in changes after accept must not matter
        push(0, 0, 10);
        k4 = FIPS_RK[0]; s4 = 1'b1; c0 = cyc;
        tick();
        s4 = 1'b0; k4 = '1;
        wait_done(0, c0, 21, "fips_done_latency");
        repeat (3) tick();
        check("idle_holds_index", rki4, 10);
        check("idle_holds_key", rk4, FIPS_RK[10]);

        // start while busy is ignored
        push(0, 0, 10);
        p0 = pulses4;
        k4 = FIPS_RK[0]; s4 = 1'b1; c0 = cyc;
        tick();
        s4 = 1'b0;
        wait_idx4(4'd4);
        s4 = 1'b1; k4 = '0;
        tick();
        s4 = 1'b0;
        wait_done(0, c0, 21, "busy_start_done_latency");
        repeat (5) tick();
        check("busy_start_pulse_count", pulses4 - p0, 11);

        // reset mid-expansion
        push(0, 0, 6);
        k4 = FIPS_RK[0]; s4 = 1'b1;
        tick();
        s4 = 1'b0;
        wait_idx4(4'd6);
        rst = 1'b1;
        tick();
        check("midrst_busy", busy4, 0);
        check("midrst_rk_valid", rkv4, 0);
        check("midrst_round_key", rk4, 0);
        rst = 1'b0;
        repeat (10) tick();
        push(0, 0, 10);
        k4 = FIPS_RK[0]; s4 = 1'b1; c0 = cyc;
        tick();
        s4 = 1'b0;
        wait_done(0, c0, 21, "post_rst_done_latency");
        tick();

        // back-to-back: start on the done cycle is dropped, the next cycle's is taken
        push(0, 0, 10);
        k4 = FIPS_RK[0]; s4 = 1'b1; c0 = cyc;
        tick();
        s4 = 1'b0;
        wait_done(0, c0, 21, "b2b_first_done_latency");
        s4 = 1'b1; k4 = '0;
        tick();
        push(0, 0, 10);
        k4 = FIPS_RK[0]; c0 = cyc;
        tick();
        s4 = 1'b0;
        check("b2b_rk0_valid", rkv4, 1);
        check("b2b_rk0_index", rki4, 0);
        wait_done(0, c0, 21, "b2b_second_done_latency");
        tick();

        // all-zero key, byte-serial S-box
        push(1, 1, 10);
        k1 = '0; s1 = 1'b1; c0 = cyc;
        tick();
        s1 = 1'b0;
        wait_done(1, c0, 51, "zero_1lane_done_latency");
        repeat (3) tick();

`ifdef KEY_SCHED_RK_STORE_EN
        rdi4 = 4'd1;  tick(); check("store_rd1", rdk4, FIPS_RK[1]);
        rdi4 = 4'd10; tick(); check("store_rd10", rdk4, FIPS_RK[10]);
        rdi4 = 4'd12; tick(); check("store_rd12", rdk4, 0);
        rdi4 = 4'd0;  tick(); check("store_rd0", rdk4, FIPS_RK[0]);
        rdi1 = 4'd10; tick(); check("store_1lane_rd10", rdk1, ZERO_RK[10]);
`endif

        check("q4_drained", q4.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
